ps2_button_mapper: RTL and testbench



---
 rtl/ps2_map_pkg.sv | 17 +
 rtl/ps2_button_cell.sv | 83 ++++++++
 rtl/ps2_button_mapper.sv | 83 ++++++++
 tb/tb_ps2_button_mapper.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ps2_map_pkg.sv
// Shared types and constants for the PS/2 scancode-to-button mapper.
// A table entry is {ext, scancode}; the all-zero entry never matches an event.
package ps2_map_pkg;

    localparam int SCAN_W = 9;

    typedef logic [SCAN_W-1:0] scan_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        PEND_REL = 2'd2
    } btn_state_t;

    localparam scan_t SCAN_NONE = 9'h000;

endpackage

// File: rtl/ps2_button_cell.sv
// One mapped button: press/release FSM, minimum-hold countdown and press-edge pulse.
// btn_nxt exposes the next-cycle level so the parent can register an OR without extra latency.
module ps2_button_cell
    import ps2_map_pkg::*;
#(
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              clear,
    input  logic              match_press,
    input  logic              match_release,
    input  logic [HOLD_W-1:0] hold_min,
    output logic              btn,
    output logic              btn_edge,
    output logic              btn_nxt
);

    btn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              edge_q, edge_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
        end
    end

    // A press reload overrides the ce decrement; PEND_REL drops on the edge where the count reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = 1'b0;
        if (ce && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (match_press) begin
                        state_d = HELD;
                        cnt_d   = hold_min;
                        edge_d  = 1'b1;
                    end
                end
                HELD: begin
                    if (match_press) begin
                        cnt_d = hold_min;
                    end else if (match_release) begin
                        state_d = (cnt_q == '0) ? IDLE : PEND_REL;
                    end
                end
                PEND_REL: begin
                    if (match_press) begin
                        state_d = HELD;
                        cnt_d   = hold_min;
                    end else if (cnt_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign btn      = (state_q != IDLE);
    assign btn_nxt  = (state_d != IDLE);
    assign btn_edge = edge_q;

endmodule

// File: rtl/ps2_button_mapper.sv
// Maps hps_io PS/2 key events onto NUM_BUTTONS button lines through a run-time loadable
// {ext, scancode} table, with per-button minimum hold, synchronous clear and press-edge pulses.
module ps2_button_mapper
    import ps2_map_pkg::*;
#(
    parameter int                               NUM_BUTTONS = 12,
    parameter int                               IDX_W       = 4,
    parameter int                               HOLD_W      = 16,
    parameter logic [SCAN_W*NUM_BUTTONS-1:0]    DEFAULT_MAP = {NUM_BUTTONS{9'h000}}
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic [10:0]            ps2_key,
    input  logic                   clear,
    input  logic [HOLD_W-1:0]      hold_min,
    input  logic                   map_wr,
    input  logic [IDX_W-1:0]       map_idx,
    input  logic [SCAN_W-1:0]      map_code,
    output logic [NUM_BUTTONS-1:0] btn,
    output logic [NUM_BUTTONS-1:0] btn_edge,
    output logic                   any_pressed
);

    logic                   strobe_q;
    logic                   primed;
    logic                   key_event;
    scan_t                  key_code;
    scan_t                  map_q [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] btn_nxt;

    // primed masks the first cycle after reset so a strobe already high is not taken as a toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q    <= 1'b0;
            primed      <= 1'b0;
            any_pressed <= 1'b0;
        end else begin
            strobe_q    <= ps2_key[10];
            primed      <= 1'b1;
            any_pressed <= |btn_nxt;
        end
    end

    assign key_event = primed && (ps2_key[10] != strobe_q);
    assign key_code  = {ps2_key[8], ps2_key[7:0]};

    // Out-of-range indices match no entry and are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                map_q[i] <= DEFAULT_MAP[SCAN_W*i +: SCAN_W];
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (map_wr && (map_idx == IDX_W'(i))) begin
                    map_q[i] <= map_code;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_cell
        logic hit;
        assign hit = key_event && (map_q[g] != SCAN_NONE) && (map_q[g] == key_code);

        ps2_button_cell #(
            .HOLD_W (HOLD_W)
        ) u_cell (
            .clk           (clk),
            .reset_n       (reset_n),
            .ce            (ce),
            .clear         (clear),
            .match_press   (hit && ps2_key[9]),
            .match_release (hit && !ps2_key[9]),
            .hold_min      (hold_min),
            .btn           (btn[g]),
            .btn_edge      (btn_edge[g]),
            .btn_nxt       (btn_nxt[g])
        );
    end

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Scoreboard bench for ps2_button_mapper: the driver queues the expected btn/btn_edge per cycle,
// a monitor pops and compares after every rising edge.
module tb_ps2_button_mapper;

    localparam int NB = 12;
    localparam logic [9*NB-1:0] TB_MAP = {{7{9'h000}}, 9'h023, 9'h16B, 9'h000, 9'h01B, 9'h01C};

    typedef struct packed {
        logic [NB-1:0] b;
        logic [NB-1:0] e;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ce;
    logic [10:0]   ps2_key;
    logic          clear;
    logic [15:0]   hold_min;
    logic          map_wr;
    logic [3:0]    map_idx;
    logic [8:0]    map_code;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_edge;
    logic          any_pressed;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    ps2_button_mapper #(
        .NUM_BUTTONS (NB),
        .IDX_W       (4),
        .HOLD_W      (16),
        .DEFAULT_MAP (TB_MAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .ps2_key     (ps2_key),
        .clear       (clear),
        .hold_min    (hold_min),
        .map_wr      (map_wr),
        .map_idx     (map_idx),
        .map_code    (map_code),
        .btn         (btn),
        .btn_edge    (btn_edge),
        .any_pressed (any_pressed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [NB-1:0] act, input logic [NB-1:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Queue the expectation for the next rising edge, then advance to the following falling edge.
    task automatic applyStimulus(input logic [NB-1:0] eb, input logic [NB-1:0] ee);
        exp_t x;
        x.b = eb;
        x.e = ee;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checkOutput("btn", btn, x.b);
            checkOutput("btn_edge", btn_edge, x.e);
            checkOutput("any_pressed", {{(NB-1){1'b0}}, any_pressed}, {{(NB-1){1'b0}}, |x.b});
        end
    end

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b1;
        ps2_key  = '0;
        clear    = 1'b0;
        hold_min = '0;
        map_wr   = 1'b0;
        map_idx  = '0;
        map_code = '0;
        @(negedge clk);
        applyStimulus(12'h000, 12'h000);
        applyStimulus(12'h000, 12'h000);
        reset_n = 1'b1;
        applyStimulus(12'h000, 12'h000);

        // basic press / release, no hold stretching
        key(1'b1, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h001);
        applyStimulus(12'h001, 12'h000);
        key(1'b0, 1'b0, 8'h1C); applyStimulus(12'h000, 12'h000);

        // extended vs plain code
        key(1'b1, 1'b0, 8'h6B); applyStimulus(12'h000, 12'h000);
        key(1'b1, 1'b1, 8'h6B); applyStimulus(12'h008, 12'h008);
        key(1'b0, 1'b1, 8'h6B); applyStimulus(12'h000, 12'h000);

        // minimum hold of five ticks, then re-press while pending release
        hold_min = 16'd5;
        key(1'b1, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h001);
        key(1'b0, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h000, 12'h000);
        key(1'b1, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h001);
        key(1'b0, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h001, 12'h000);
        key(1'b1, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h000);
        applyStimulus(12'h001, 12'h000);

        // clear beats a simultaneous press
        key(1'b1, 1'b0, 8'h1B); applyStimulus(12'h003, 12'h002);
        key(1'b1, 1'b1, 8'h6B); applyStimulus(12'h00B, 12'h008);
        clear = 1'b1;
        key(1'b1, 1'b0, 8'h23); applyStimulus(12'h000, 12'h000);
        clear = 1'b0;
        applyStimulus(12'h000, 12'h000);
        hold_min = 16'd0;

        // table writes: same-cycle event uses old entry; out-of-range index ignored
        map_wr = 1'b1; map_idx = 4'd2; map_code = 9'h029;
        key(1'b1, 1'b0, 8'h29); applyStimulus(12'h000, 12'h000);
        map_wr = 1'b0;
        key(1'b1, 1'b0, 8'h29); applyStimulus(12'h004, 12'h004);
        key(1'b0, 1'b0, 8'h29); applyStimulus(12'h000, 12'h000);
        map_wr = 1'b1; map_idx = 4'd15; map_code = 9'h01C;
        applyStimulus(12'h000, 12'h000);
        map_wr = 1'b0;
        key(1'b1, 1'b1, 8'h6B); applyStimulus(12'h008, 12'h008);
        key(1'b0, 1'b1, 8'h6B); applyStimulus(12'h000, 12'h000);
        key(1'b1, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h001);
        key(1'b0, 1'b0, 8'h1C); applyStimulus(12'h000, 12'h000);

        // reset during pending release restores the default table
        hold_min = 16'd5;
        map_wr = 1'b1; map_idx = 4'd0; map_code = 9'h01A;
        applyStimulus(12'h000, 12'h000);
        map_wr = 1'b0;
        key(1'b1, 1'b0, 8'h1A); applyStimulus(12'h001, 12'h001);
        key(1'b0, 1'b0, 8'h1A); applyStimulus(12'h001, 12'h000);
        reset_n = 1'b0;
        #1;
        checkOutput("async_btn", btn, 12'h000);
        checkOutput("async_any", {{(NB-1){1'b0}}, any_pressed}, 12'h000);
        ps2_key  = {1'b1, 1'b1, 1'b0, 8'h1C};
        hold_min = 16'd0;
        applyStimulus(12'h000, 12'h000);
        applyStimulus(12'h000, 12'h000);
        reset_n = 1'b1;
        applyStimulus(12'h000, 12'h000);
        applyStimulus(12'h000, 12'h000);
        key(1'b1, 1'b0, 8'h1C); applyStimulus(12'h001, 12'h001);
        key(1'b0, 1'b0, 8'h1A); applyStimulus(12'h001, 12'h000);
        key(1'b0, 1'b0, 8'h1C); applyStimulus(12'h000, 12'h000);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
